// File: rtl/prio_encoder_rr_pkg.sv
// prio_encoder_rr_pkg: shared mode encoding and statistics counter width
package prio_encoder_rr_pkg;
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;
  localparam int STATS_W = 16;
endpackage

// File: rtl/prio_encoder_rr_find_first.sv
// prio_find_first: first set bit at or above a base index, wrapping to the lowest set bit
module prio_find_first #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  input  logic [IDX_W-1:0] i_base,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot,
  output logic             o_found
);
  logic [IDX_W-1:0] w_hi_idx, w_lo_idx;
  logic             w_hi_found, w_lo_found;
  // Two-pass search: lowest set bit at/above base, and lowest set bit overall as the wrap fallback
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        w_lo_idx   = IDX_W'(i);
        w_lo_found = 1'b1;
      end
      if (i_vec[i] && i >= int'(i_base)) begin
        w_hi_idx   = IDX_W'(i);
        w_hi_found = 1'b1;
      end
    end
  end
  assign o_found  = w_lo_found;
  assign o_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_onehot = w_lo_found ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: fixed/round-robin priority encoder with valid/ready handshake; PRIO_ENCODER_RR_STATS_EN adds a grant counter
module prio_encoder_rr
  import prio_encoder_rr_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       d,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   y,
  output logic [N-1:0]       grant,
  output logic               none,
`ifdef PRIO_ENCODER_RR_STATS_EN
  output logic               multi,
  output logic [STATS_W-1:0] grant_cnt,
  input  logic               cnt_clr
`else
  output logic               multi
`endif
);
  logic [IDX_W-1:0] r_ptr, r_y, w_idx, w_base;
  logic [N-1:0]     r_grant, w_onehot;
  logic             r_out_valid, r_none, r_multi;
  logic             w_found, w_accept, w_multi, w_rr;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_rr     = mode == MODE_RR;
  assign w_base   = w_rr ? r_ptr : '0;
  assign w_multi  = |(d & (d - N'(1)));

  prio_find_first #(.N(N)) u_find (
    .i_vec    (d),
    .i_base   (w_base),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_found  (w_found)
  );

  // Single-entry output register: load on accept, drain on consumer handshake, advance RR pointer past a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_grant     <= '0;
      r_none      <= 1'b0;
      r_multi     <= 1'b0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_idx;
      r_grant     <= w_onehot;
      r_none      <= !w_found;
      r_multi     <= w_multi;
      if (w_rr && w_found) r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign grant     = r_grant;
  assign none      = r_none;
  assign multi     = r_multi;

`ifdef PRIO_ENCODER_RR_STATS_EN
  logic [STATS_W-1:0] r_cnt;
  // Saturating count of nonzero accepts; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) r_cnt <= '0;
    else if (w_accept && w_found && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign grant_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: scoreboard bench for prio_encoder_rr at N=8 and N=5
module tb_prio_encoder_rr;
  typedef struct packed {
    logic [2:0] y;
    logic [7:0] grant;
    logic       none;
    logic       multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready = 1'b1, none, multi;
  logic [7:0] d = '0, grant;
  logic [2:0] y;
  logic in_valid5 = 1'b0, in_ready5, mode5 = 1'b1, out_valid5, out_ready5 = 1'b1, none5, multi5;
  logic [4:0] d5 = '0, grant5;
  logic [2:0] y5;
`ifdef PRIO_ENCODER_RR_STATS_EN
  logic [15:0] grant_cnt, grant_cnt5;
  logic cnt_clr = 1'b0;
  logic cnt_clr5 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  exp_t q[$];
  int q5[$];

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .grant(grant), .none(none),
`ifdef PRIO_ENCODER_RR_STATS_EN
    .grant_cnt(grant_cnt), .cnt_clr(cnt_clr),
`endif
    .multi(multi)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .d(d5), .mode(mode5),
    .out_valid(out_valid5), .out_ready(out_ready5), .y(y5), .grant(grant5), .none(none5),
`ifdef PRIO_ENCODER_RR_STATS_EN
    .grant_cnt(grant_cnt5), .cnt_clr(cnt_clr5),
`endif
    .multi(multi5)
  );

  // Drive one transaction from a negedge (out_ready=1 so it is accepted) and push the model's prediction
  task automatic xfer(input logic [7:0] v, input logic m);
    exp_t e;
    int b;
    b = m ? m_ptr : 0;
    e = '0;
    e.none = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (b + k) % 8;
      if (e.none && v[idx]) begin
        e.none = 1'b0;
        e.y = 3'(idx);
        e.grant = 8'(1 << idx);
      end
    end
    e.multi = $countones(v) > 1;
    if (m && !e.none) m_ptr = (int'(e.y) + 1) % 8;
    q.push_back(e);
    in_valid = 1'b1;
    d = v;
    mode = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || y !== 3'd0 || grant !== 8'h00 || none !== 1'b0 || multi !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got v=%b y=%0d g=%h n=%b m=%b rdy=%b exp all zero, rdy=1", out_valid, y, grant, none, multi, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed;
    logic [7:0] vecs [4] = '{8'h80, 8'h2C, 8'h01, 8'hFF};
    exp_t e;
    foreach (vecs[i]) begin
      xfer(vecs[i], 1'b0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e.y || grant !== e.grant || none !== e.none || multi !== e.multi) begin
        errors++;
        $display("FAIL fixed[%0d]: got v=%b y=%0d g=%h n=%b m=%b exp y=%0d g=%h n=%b m=%b", i, out_valid, y, grant, none, multi, e.y, e.grant, e.none, e.multi);
      end
    end
  endtask

  task automatic test_rr;
    logic [2:0] seq [4] = '{3'd0, 3'd2, 3'd7, 3'd0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      xfer(8'b1000_0101, 1'b1);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e.y || y !== seq[i] || grant !== e.grant || none !== e.none || multi !== e.multi) begin
        errors++;
        $display("FAIL rr[%0d]: got v=%b y=%0d g=%h n=%b m=%b exp y=%0d g=%h n=%b m=%b", i, out_valid, y, grant, none, multi, e.y, e.grant, e.none, e.multi);
      end
    end
  endtask

  task automatic test_zero;
    logic [7:0] vecs [5] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'hFF};
    logic       mods [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e;
    foreach (vecs[i]) begin
      xfer(vecs[i], mods[i]);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e.y || grant !== e.grant || none !== e.none || multi !== e.multi) begin
        errors++;
        $display("FAIL zero[%0d]: got v=%b y=%0d g=%h n=%b m=%b exp y=%0d g=%h n=%b m=%b", i, out_valid, y, grant, none, multi, e.y, e.grant, e.none, e.multi);
      end
    end
    checks++;
    if (y !== 3'd3) begin
      errors++;
      $display("FAIL zero_ptr: got y=%0d exp y=3", y);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    xfer(8'h10, 1'b0);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || grant !== e.grant) begin
      errors++;
      $display("FAIL bp_first: got v=%b y=%0d g=%h exp y=%0d g=%h", out_valid, y, grant, e.y, e.grant);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    d = 8'h02;
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== e.y || grant !== e.grant || none !== e.none || multi !== e.multi) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b y=%0d g=%h exp rdy=0 v=1 y=%0d g=%h", i, in_ready, out_valid, y, grant, e.y, e.grant);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    xfer(8'h02, 1'b0);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || grant !== e.grant || none !== e.none || multi !== e.multi) begin
      errors++;
      $display("FAIL bp_replace: got v=%b y=%0d g=%h exp y=%0d g=%h", out_valid, y, grant, e.y, e.grant);
    end
    xfer(8'h40, 1'b0);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || grant !== e.grant) begin
      errors++;
      $display("FAIL bp_stream: got v=%b y=%0d g=%h exp y=%0d g=%h", out_valid, y, grant, e.y, e.grant);
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    xfer(8'h10, 1'b1);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || y !== 3'd4) begin
      errors++;
      $display("FAIL mrst_pre: got v=%b y=%0d exp v=1 y=4", out_valid, y);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    d = 8'hFF;
    mode = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    m_ptr = 0;
    checks++;
    if (out_valid !== 1'b0 || y !== 3'd0 || grant !== 8'h00 || none !== 1'b0 || multi !== 1'b0) begin
      errors++;
      $display("FAIL mrst: got v=%b y=%0d g=%h n=%b m=%b exp all zero", out_valid, y, grant, none, multi);
    end
    xfer(8'hFF, 1'b1);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || y !== 3'd0 || grant !== e.grant || multi !== e.multi) begin
      errors++;
      $display("FAIL mrst_post: got v=%b y=%0d g=%h exp y=0 g=%h", out_valid, y, grant, e.grant);
    end
  endtask

  task automatic test_n5;
    int e;
    for (int i = 0; i < 4; i++) begin
      q5.push_back((i % 2) ? 4 : 0);
      in_valid5 = 1'b1;
      d5 = 5'b10001;
      mode5 = 1'b1;
      @(negedge clk);
      in_valid5 = 1'b0;
      e = q5.pop_front();
      checks++;
      if (out_valid5 !== 1'b1 || y5 !== 3'(e) || grant5 !== 5'(1 << e) || multi5 !== 1'b1 || none5 !== 1'b0 || y5 > 3'd4) begin
        errors++;
        $display("FAIL n5[%0d]: got v=%b y=%0d g=%b m=%b exp y=%0d g=%b m=1", i, out_valid5, y5, grant5, multi5, e, 5'(1 << e));
      end
    end
  endtask

`ifdef PRIO_ENCODER_RR_STATS_EN
  task automatic test_stats;
    exp_t e;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    xfer(8'h01, 1'b0);
    xfer(8'h02, 1'b0);
    xfer(8'h00, 1'b0);
    xfer(8'hFF, 1'b0);
    checks++;
    if (grant_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stats_cnt: got %0d exp 3", grant_cnt);
    end
    cnt_clr = 1'b1;
    xfer(8'h03, 1'b0);
    cnt_clr = 1'b0;
    checks++;
    if (grant_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_clr: got %0d exp 0", grant_cnt);
    end
    while (q.size() > 1) void'(q.pop_front());
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || grant !== e.grant || multi !== e.multi) begin
      errors++;
      $display("FAIL stats_xfer: got y=%0d g=%h exp y=%0d g=%h", y, grant, e.y, e.grant);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_fixed;
    test_rr;
    test_zero;
    test_back_to_back;
    test_mid_reset;
    test_n5;
`ifdef PRIO_ENCODER_RR_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised successor to the team's fixed 8-to-3 one-hot encoder.
- Accepts an N-bit request vector of any population (zero, one-hot or multi-hot) through a valid/ready handshake.
- Selects one set bit by fixed-priority or round-robin arbitration and emits a registered binary index, one-hot grant and status flags.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request lines; N >= 2; non-power-of-two allowed.
- IDX_W, $clog2(N), index width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request vector present
- in_ready  output  1  block can accept this cycle
- d  input  N  request vector
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled at acceptance
- out_valid  output  1  result held in output register
- out_ready  input  1  consumer accepts result
- y  output  IDX_W  encoded index of granted bit
- grant  output  N  one-hot of granted bit; all-zero if d was zero
- none  output  1  accepted d was all-zero
- multi  output  1  accepted d had more than one bit set

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, y=0, grant=0, none=0, multi=0.
  - RR pointer ptr=0.
  - Any held result is discarded.
  - Reset dominates all other inputs in the same cycle.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational; it is a single-entry pipeline register.
  - Accept = in_valid && in_ready. On accept, the result registers load and out_valid=1 on the next edge. Latency is 1 cycle.
  - If out_valid && out_ready && !accept, then out_valid goes to 0 next cycle.
  - Simultaneous output handshake and new accept: the new result replaces the old one with no bubble. Full throughput is 1 per cycle.
  - Output fields are stable while out_valid && !out_ready.
  - d and mode are don't-care when in_valid=0.
- Fixed mode (mode=0): the lowest set index wins. d=8'b0010_1100 gives y=2.
- Round-robin mode (mode=1):
  - Search starts at ptr, ascending, and wraps at N-1 to 0. The first set bit wins.
  - After a nonzero accept, ptr <= (y_new == N-1) ? 0 : y_new+1.
- Pointer rules:
  - ptr is unchanged by fixed-mode accepts and by zero-vector accepts.
  - Mode can change per transaction; ptr persists across mode changes.
- Zero vector:
  - The accept still occurs and produces a result: none=1, grant=0, y=0, multi=0.
- Flags:
  - multi=1 iff popcount(d) >= 2.
  - none and multi are mutually exclusive.
- Non-power-of-two N: y never exceeds N-1, and the wrap is explicit. Do not rely on IDX_W overflow.

Optional Feature:
- Macro: PRIO_ENCODER_RR_STATS_EN.
- When defined:
  - Adds output grant_cnt, 16 bits. It counts accepts with a nonzero d and saturates at 16'hFFFF.
  - Adds input cnt_clr, 1 bit. It is synchronous; it zeroes the count and has priority over an increment in the same cycle.
  - rst also zeroes the count.
- When undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Package prio_encoder_rr_pkg holds:
  - the mode typedef (MODE_FIXED=1'b0, MODE_RR=1'b1);
  - the counter width constant STATS_W=16.
- One sub-module, prio_find_first. It is purely combinational.
  - Inputs: N-bit vector and base index.
  - Outputs: index, one-hot and found.
  - Implementation: a doubled-vector or masked two-pass search.
  - The top level owns all registers, the handshake and ptr.

Test Plan:
- Reset, then fixed mode, N=8: d=8'b1000_0000 -> y=7, grant=8'h80, multi=0, none=0. Then d=8'h2C -> y=2, multi=1. Each result appears one cycle after accept.
- RR mode, d held at 8'b1000_0101 for 4 accepts -> y sequence 0, 2, 7, 0. ptr wraps from 7 to 0.
- Zero vector in each mode -> none=1, y=0, grant=0. ptr unchanged: the next RR accept of 8'hFF after y=2 gives y=3.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output frozen, no accept. Then out_ready=1 with a new d in the same cycle -> replaced with no bubble.
- Mid-operation reset: out_valid=1, ptr=5, then assert rst -> next cycle out_valid=0. RR accept of 8'hFF -> y=0.
- N=5 (non-power-of-two), RR mode with d=5'b10001 repeated -> y sequence 0, 4, 0, 4. y never reaches 5–7.
- With PRIO_ENCODER_RR_STATS_EN: 3 nonzero plus 1 zero accept -> grant_cnt=3. Then cnt_clr together with an accept -> grant_cnt=0.
